trigger_waveform_capture: RTL
=============================

TRIGGER_WAVEFORM_CAPTURE -- requirements
Module: trigger_waveform_capture

Interface
REQ-001 SHALL have parameter PRE_SAMPLES, default 32: samples stored before the accepted trigger, 1..128.
REQ-002 SHALL have parameter POST_SAMPLES, default 96: samples stored from the trigger cycle onward, 1..128; PRE_SAMPLES+POST_SAMPLES = N <= 256.
REQ-003 SHALL have port clk  in  1  sole clock; all logic rising-edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port enable  in  1  sample strobe; x and trigger are sampled only when high.
REQ-006 SHALL have port x  in  16  signed filtered sample from the CFD trigger source.
REQ-007 SHALL have port trigger  in  1  level trigger from the CFD trigger source; held high for many cycles.
REQ-008 SHALL have port dout  out  16  frame word.
REQ-009 SHALL have port dout_valid  out  1  dout holds a valid word.
REQ-010 SHALL have port dout_ready  in  1  consumer accepts the word.
REQ-011 SHALL have port dout_last  out  1  final word of the frame, qualified by dout_valid.
REQ-012 SHALL have port busy  out  1  high in the CAPTURE and READOUT states.
REQ-013 SHALL have port dropped  out  16  saturating count of triggers that were not accepted.

Function
REQ-014 SHALL store samples in a 256-word ring with an 8-bit write pointer wp; wp wraps 255->0.
REQ-015 SHALL implement the states IDLE, CAPTURE and READOUT.
REQ-016 IDLE SHALL write x to ring[wp] and increment wp on every enable cycle.
REQ-017 IDLE SHALL increment a fill counter on every enable cycle, saturating at PRE_SAMPLES; the block is armed when the fill counter equals PRE_SAMPLES.
REQ-018 SHALL detect a trigger edge as trigger=1 on an enable cycle where trigger was 0 on the previous enable cycle.
REQ-019 A trigger edge while armed in IDLE SHALL be accepted: start = wp - PRE_SAMPLES (mod 256); the trigger-cycle sample is written and is post-sample 1; state goes to CAPTURE.
REQ-020 CAPTURE SHALL write samples on enable cycles until POST_SAMPLES post-samples are stored, then go to READOUT on the next cycle.
REQ-021 If POST_SAMPLES = 1, the block SHALL go directly from the trigger cycle to READOUT.
REQ-022 READOUT SHALL perform no ring writes; samples arriving during READOUT are discarded.
REQ-023 READOUT SHALL stream N words, ring[start] through ring[start+N-1] (mod 256), in order.
REQ-024 The first dout_valid SHALL assert no later than 2 cycles after entering READOUT.
REQ-025 A word SHALL transfer on dout_valid && dout_ready.
REQ-026 While dout_valid && !dout_ready, dout and dout_last SHALL hold stable.
REQ-027 Back-to-back transfers at 1 word/cycle SHALL be supported.
REQ-028 dout_last SHALL assert with word N only.
REQ-029 After the last transfer, the block SHALL clear the fill counter, return to IDLE and continue writing at the current wp.
REQ-030 A trigger edge while not armed, in CAPTURE or in READOUT SHALL increment dropped, saturating at 0xFFFF; the count is never cleared except by reset.
REQ-031 A trigger level held across the return to IDLE SHALL NOT be accepted; only a new edge is accepted.
REQ-032 With enable=0, sample writes and edge detection SHALL be frozen; READOUT continues.

Reset
REQ-033 Asserting reset SHALL at once force: state IDLE, wp=0, fill=0, dropped=0, dout=0, dout_valid=0, dout_last=0, busy=0, previous-trigger flag=0.
REQ-034 Reset asserted mid-CAPTURE or mid-READOUT SHALL abandon the frame with no further dout_valid; ring contents need not be cleared.

Configuration
REQ-035 With macro CAPTURE_TIMESTAMP_EN defined, the block SHALL add input timestamp (64 bits, same clock).
REQ-036 With CAPTURE_TIMESTAMP_EN defined, the block SHALL latch timestamp on the accepted trigger cycle.
REQ-037 With CAPTURE_TIMESTAMP_EN defined, the block SHALL prefix each frame with 4 header words, timestamp[15:0] first through [63:48]; frame length becomes N+4, and dout_last remains on the final sample word.
REQ-038 Without CAPTURE_TIMESTAMP_EN, the timestamp port and header SHALL be absent and frames SHALL be exactly N words.

Verification
REQ-039 Ramp x=0,1,2,... (enable=1); trigger edge at x=100; dout_ready=1 -> 128 words 68..195, dout_last on 195, busy low after the last transfer.
REQ-040 Trigger edge after only 10 samples since reset -> no frame, dropped=1.
REQ-041 Second trigger edge during CAPTURE, then another during READOUT -> one frame only, dropped=2.
REQ-042 Trigger at wp=20 (after the ring has wrapped) -> words read from ring addresses 244..255 then 0..115, no corruption.
REQ-043 dout_ready toggling 1/0 every cycle -> 128 words, each held stable while unaccepted; reset asserted at word 50 -> dout_valid=0 immediately, dropped=0.
REQ-044 CAPTURE_TIMESTAMP_EN build with timestamp=0x0123456789ABCDEF at the trigger -> header 0xCDEF, 0x89AB, 0x4567, 0x0123, then 128 samples.

Source files
------------

// File: rtl/trigger_waveform_capture.sv
// Trigger-driven waveform capture.
// A 256-word ring records x continuously while idle. An accepted trigger edge
// freezes PRE_SAMPLES history, records POST_SAMPLES more, then streams the
// frame out over a valid/ready port.
// Optional build macro CAPTURE_TIMESTAMP_EN: adds a 64-bit timestamp input
// that is latched on the accepted trigger and sent as 4 header words.
// Ports:
//   clk, reset (async, active high)
//   enable, x[15:0], trigger      - sample strobe, sample, level trigger
//   timestamp[63:0]               - only with CAPTURE_TIMESTAMP_EN
//   dout[15:0], dout_valid, dout_ready, dout_last - frame stream
//   busy                          - capturing or reading out
//   dropped[15:0]                 - saturating count of rejected trigger edges
module trigger_waveform_capture #(
    parameter int unsigned PRE_SAMPLES  = 32,
    parameter int unsigned POST_SAMPLES = 96
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] x,
    input  logic        trigger,
`ifdef CAPTURE_TIMESTAMP_EN
    input  logic [63:0] timestamp,
`endif
    output logic [15:0] dout,
    output logic        dout_valid,
    input  logic        dout_ready,
    output logic        dout_last,
    output logic        busy,
    output logic [15:0] dropped
);

    localparam int unsigned N_WORDS = PRE_SAMPLES + POST_SAMPLES;
`ifdef CAPTURE_TIMESTAMP_EN
    localparam int unsigned HDR_WORDS = 4;
`else
    localparam int unsigned HDR_WORDS = 0;
`endif
    localparam int unsigned FRAME_WORDS = N_WORDS + HDR_WORDS;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CAPTURE = 2'd1;
    localparam logic [1:0] ST_READOUT = 2'd2;

    logic [15:0] ring_mem [256];

    logic [1:0]  state_q,   state_d;
    logic [7:0]  wp_q,      wp_d;
    logic [7:0]  fill_q,    fill_d;
    logic        prev_q,    prev_d;
    logic [15:0] dropped_q, dropped_d;
    logic [7:0]  start_q,   start_d;
    logic [7:0]  post_q,    post_d;
    logic [8:0]  rd_q,      rd_d;
    logic [15:0] dout_q,    dout_d;
    logic        valid_q,   valid_d;
    logic        last_q,    last_d;
    logic        busy_q,    busy_d;
`ifdef CAPTURE_TIMESTAMP_EN
    logic [63:0] ts_q,      ts_d;
`endif

    logic        we_c;
    logic        edge_c;
    logic        drop_c;
    logic [15:0] rd_word_c;

    // Word for frame position rd_q: header words first (if built), then ring.
    always_comb begin
`ifdef CAPTURE_TIMESTAMP_EN
        if (rd_q < 9'(HDR_WORDS)) begin
            rd_word_c = ts_q[{rd_q[1:0], 4'b0000} +: 16];
        end else begin
            rd_word_c = ring_mem[start_q + rd_q[7:0] - 8'(HDR_WORDS)];
        end
`else
        rd_word_c = ring_mem[start_q + rd_q[7:0]];
`endif
    end

    // Next-state and output logic.
    always_comb begin
        state_d   = state_q;
        wp_d      = wp_q;
        fill_d    = fill_q;
        prev_d    = prev_q;
        dropped_d = dropped_q;
        start_d   = start_q;
        post_d    = post_q;
        rd_d      = rd_q;
        dout_d    = dout_q;
        valid_d   = valid_q;
        last_d    = last_q;
`ifdef CAPTURE_TIMESTAMP_EN
        ts_d      = ts_q;
`endif
        we_c      = 1'b0;
        drop_c    = 1'b0;

        // Edge detection only advances on enable cycles, in every state, so
        // a level held across the return to idle is never seen as a new edge.
        edge_c = enable && trigger && !prev_q;
        if (enable) begin
            prev_d = trigger;
        end

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    we_c = 1'b1;
                    wp_d = wp_q + 8'd1;
                    if (fill_q != 8'(PRE_SAMPLES)) begin
                        fill_d = fill_q + 8'd1;
                    end
                    if (edge_c) begin
                        if (fill_q == 8'(PRE_SAMPLES)) begin
                            // Trigger-cycle sample counts as post-sample 1.
                            start_d = wp_q - 8'(PRE_SAMPLES);
                            post_d  = 8'd1;
                            rd_d    = 9'd0;
`ifdef CAPTURE_TIMESTAMP_EN
                            ts_d    = timestamp;
`endif
                            state_d = (POST_SAMPLES == 1) ? ST_READOUT : ST_CAPTURE;
                        end else begin
                            drop_c = 1'b1;
                        end
                    end
                end
            end
            ST_CAPTURE: begin
                if (edge_c) begin
                    drop_c = 1'b1;
                end
                if (enable) begin
                    we_c   = 1'b1;
                    wp_d   = wp_q + 8'd1;
                    post_d = post_q + 8'd1;
                    if (post_q + 8'd1 == 8'(POST_SAMPLES)) begin
                        state_d = ST_READOUT;
                    end
                end
            end
            ST_READOUT: begin
                if (edge_c) begin
                    drop_c = 1'b1;
                end
                if (valid_q && dout_ready && last_q) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    fill_d  = 8'd0;
                    state_d = ST_IDLE;
                end else if (!valid_q || dout_ready) begin
                    // Output register is empty or draining: load the next word.
                    if (rd_q < 9'(FRAME_WORDS)) begin
                        dout_d  = rd_word_c;
                        valid_d = 1'b1;
                        last_d  = (rd_q == 9'(FRAME_WORDS - 1));
                        rd_d    = rd_q + 9'd1;
                    end else begin
                        valid_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (drop_c && (dropped_q != 16'hFFFF)) begin
            dropped_d = dropped_q + 16'd1;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // Control and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            wp_q      <= 8'd0;
            fill_q    <= 8'd0;
            prev_q    <= 1'b0;
            dropped_q <= 16'd0;
            start_q   <= 8'd0;
            post_q    <= 8'd0;
            rd_q      <= 9'd0;
            dout_q    <= 16'd0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            busy_q    <= 1'b0;
`ifdef CAPTURE_TIMESTAMP_EN
            ts_q      <= 64'd0;
`endif
        end else begin
            state_q   <= state_d;
            wp_q      <= wp_d;
            fill_q    <= fill_d;
            prev_q    <= prev_d;
            dropped_q <= dropped_d;
            start_q   <= start_d;
            post_q    <= post_d;
            rd_q      <= rd_d;
            dout_q    <= dout_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            busy_q    <= busy_d;
`ifdef CAPTURE_TIMESTAMP_EN
            ts_q      <= ts_d;
`endif
        end
    end

    // Sample ring; contents survive reset.
    always_ff @(posedge clk) begin
        if (we_c) begin
            ring_mem[wp_q] <= x;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign dout_last  = last_q;
    assign busy       = busy_q;
    assign dropped    = dropped_q;

endmodule
